// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial ripple-borrow subtractor. It computes a - b one bit per clock,
//   LSB first, using one full-subtractor cell and a borrow flop. The operands
//   are captured when start is seen in IDLE. The result appears WIDTH cycles
//   later, together with a one-cycle done pulse.
//
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   start  : operation request, sampled only in IDLE
//   a, b   : unsigned minuend / subtrahend, captured on the accepting edge
//   diff   : registered (a - b) mod 2^WIDTH, held until the next completion
//   bout   : registered final borrow (1 iff a < b)
//   busy   : high while bits are being processed
//   done   : one-cycle pulse after diff/bout update
module serial_subtractor #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH < 2) ? 1 : $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] d_sh_reg;
  logic             br_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] diff_reg;
  logic             bout_reg;

  // Full-subtractor cell working on the current LSBs.
  logic             a_bit;
  logic             b_bit;
  logic             d_bit;
  logic             br_next;
  logic [WIDTH-1:0] d_sh_next;
  logic             last_bit;

  assign a_bit     = a_sh_reg[0];
  assign b_bit     = b_sh_reg[0];
  assign d_bit     = a_bit ^ b_bit ^ br_reg;
  assign br_next   = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_reg);
  // The new bit enters at the MSB, so after WIDTH shifts bit 0 sits at the LSB.
  assign d_sh_next = {d_bit, d_sh_reg[WIDTH-1:1]};
  assign last_bit  = (cnt_reg == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      d_sh_reg  <= '0;
      br_reg    <= 1'b0;
      cnt_reg   <= '0;
      diff_reg  <= '0;
      bout_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_sh_reg  <= a;
            b_sh_reg  <= b;
            d_sh_reg  <= '0;
            br_reg    <= 1'b0;
            cnt_reg   <= '0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          a_sh_reg <= a_sh_reg >> 1;
          b_sh_reg <= b_sh_reg >> 1;
          d_sh_reg <= d_sh_next;
          br_reg   <= br_next;
          cnt_reg  <= cnt_reg + CW'(1);
          if (last_bit) begin
            // Outputs change only here, so they never show a partial result.
            diff_reg  <= d_sh_next;
            bout_reg  <= br_next;
            state_reg <= DONE;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // busy and done are decoded from the state flop only, so inputs have no
  // combinational path to them, and they can never be high together.
  assign busy = (state_reg == RUN);
  assign done = (state_reg == DONE);
  assign diff = diff_reg;
  assign bout = bout_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Directed bench for serial_subtractor. It uses a WIDTH=3 instance for the
//   protocol scenarios and a WIDTH=8 instance for the wide and random checks.
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;

  logic       start3;
  logic [2:0] a3, b3, diff3;
  logic       bout3, busy3, done3;

  logic       start8;
  logic [7:0] a8, b8, diff8;
  logic       bout8, busy8, done8;

  int n_checks = 0;
  int n_fail   = 0;

  serial_subtractor #(.WIDTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3),
    .diff(diff3), .bout(bout3), .busy(busy3), .done(done3)
  );

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .diff(diff8), .bout(bout8), .busy(busy8), .done(done8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one WIDTH=3 operation with a single-cycle start. Then wait, with a
  // bound, for done. busy is counted on every sample from E0 up to done.
  task automatic run3(input logic [2:0] ta, input logic [2:0] tb,
                      output logic [2:0] od, output logic ob,
                      output int nbusy, output bit tmo);
    od = '0; ob = 1'b0; nbusy = 0; tmo = 1'b1;
    a3 = ta; b3 = tb; start3 = 1'b1;
    step();
    start3 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done3) begin
        od = diff3; ob = bout3; tmo = 1'b0;
        break;
      end
      if (busy3) nbusy++;
      step();
    end
  endtask

  task automatic run8(input logic [7:0] ta, input logic [7:0] tb,
                      output logic [7:0] od, output logic ob,
                      output int nbusy, output bit tmo);
    od = '0; ob = 1'b0; nbusy = 0; tmo = 1'b1;
    a8 = ta; b8 = tb; start8 = 1'b1;
    step();
    start8 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (done8) begin
        od = diff8; ob = bout8; tmo = 1'b0;
        break;
      end
      if (busy8) nbusy++;
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_checks++;
    if ({diff3, bout3, busy3, done3} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_w3: got diff=%0d bout=%b busy=%b done=%b, want all 0",
               diff3, bout3, busy3, done3);
    end
    n_checks++;
    if ({diff8, bout8, busy8, done8} !== 11'b0) begin
      n_fail++;
      $display("FAIL reset_w8: got diff=%0h bout=%b busy=%b done=%b, want all 0",
               diff8, bout8, busy8, done8);
    end
    step();
    rst_n = 1'b1;
    step();
    $display("reset: outputs cleared");
  endtask

  task automatic test_basic();
    // 5 - 3: busy must stay high after E0, E1 and E2, then done after E3.
    a3 = 3'd5; b3 = 3'd3; start3 = 1'b1;
    step();
    start3 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (busy3 !== 1'b1 || done3 !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_busy[%0d]: got busy=%b done=%b, want busy=1 done=0",
                 i, busy3, done3);
      end
      a3 = 3'd0; b3 = 3'd7;  // input changes during RUN must not matter
      step();
    end
    n_checks++;
    if (done3 !== 1'b1 || busy3 !== 1'b0 || diff3 !== 3'd2 || bout3 !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done: got done=%b busy=%b diff=%0d bout=%b, want 1 0 2 0",
               done3, busy3, diff3, bout3);
    end
    step();
    n_checks++;
    if (done3 !== 1'b0 || diff3 !== 3'd2 || bout3 !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_hold: got done=%b diff=%0d bout=%b, want 0 2 0",
               done3, diff3, bout3);
    end
    $display("basic: 5-3 -> diff=%0d bout=%b", diff3, bout3);
  endtask

  task automatic test_vectors();
    logic [2:0] va [3] = '{3'd3, 3'd7, 3'd0};
    logic [2:0] vb [3] = '{3'd5, 3'd7, 3'd7};
    logic [2:0] vd [3] = '{3'd6, 3'd0, 3'd1};
    logic       vo [3] = '{1'b1, 1'b0, 1'b1};
    logic [2:0] od;
    logic       ob;
    int         nb;
    bit         tmo;
    for (int i = 0; i < 3; i++) begin
      run3(va[i], vb[i], od, ob, nb, tmo);
      n_checks++;
      if (tmo || od !== vd[i] || ob !== vo[i] || nb != 3) begin
        n_fail++;
        $display("FAIL vec_%0d_%0d: got diff=%0d bout=%b busy_cycles=%0d timeout=%b, want diff=%0d bout=%b busy_cycles=3",
                 va[i], vb[i], od, ob, nb, tmo, vd[i], vo[i]);
      end
      $display("vector: %0d-%0d -> diff=%0d bout=%b", va[i], vb[i], od, ob);
      step();
    end
  endtask

  task automatic test_ignore_start();
    int ndone = 0;
    a3 = 3'd6; b3 = 3'd1; start3 = 1'b1;
    step();                          // E0 accepts 6-1
    a3 = 3'd0; b3 = 3'd7;            // request seen at E1, while in RUN
    step();
    start3 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done3) begin
        ndone++;
        n_checks++;
        if (diff3 !== 3'd5 || bout3 !== 1'b0) begin
          n_fail++;
          $display("FAIL ignore_result: got diff=%0d bout=%b, want 5 0", diff3, bout3);
        end
      end
      step();
    end
    n_checks++;
    if (ndone != 1) begin
      n_fail++;
      $display("FAIL ignore_count: got %0d done pulses, want 1", ndone);
    end
    $display("ignore_start: done pulses=%0d diff=%0d", ndone, diff3);
  endtask

  task automatic test_reset_midop();
    int         ndone = 0;
    logic [2:0] od;
    logic       ob;
    int         nb;
    bit         tmo;
    a3 = 3'd4; b3 = 3'd1; start3 = 1'b1;
    step();                          // E0
    start3 = 1'b0;
    step();                          // E1
    step();                          // E2: second RUN cycle done
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({diff3, bout3, busy3, done3} !== 6'b0) begin
      n_fail++;
      $display("FAIL midop_reset: got diff=%0d bout=%b busy=%b done=%b, want all 0",
               diff3, bout3, busy3, done3);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (done3) ndone++;
      step();
    end
    n_checks++;
    if (ndone != 0) begin
      n_fail++;
      $display("FAIL midop_nodone: got %0d done pulses, want 0", ndone);
    end
    run3(3'd2, 3'd1, od, ob, nb, tmo);
    n_checks++;
    if (tmo || od !== 3'd1 || ob !== 1'b0) begin
      n_fail++;
      $display("FAIL midop_next: got diff=%0d bout=%b timeout=%b, want 1 0 0", od, ob, tmo);
    end
    $display("reset_midop: next op 2-1 -> diff=%0d bout=%b", od, ob);
    step();
  endtask

  task automatic test_back_to_back();
    int first_done  = -1;
    int second_done = -1;
    a3 = 3'd3; b3 = 3'd1; start3 = 1'b1;
    for (int e = 0; e < 12; e++) begin
      step();                        // sample after edge E_e
      if (e == 0) begin
        a3 = 3'd1; b3 = 3'd3;        // taken by the next accept at E5
      end
      if (done3) begin
        if (first_done < 0) begin
          first_done = e;
          n_checks++;
          if (diff3 !== 3'd2 || bout3 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_first: got diff=%0d bout=%b, want 2 0", diff3, bout3);
          end
        end else if (second_done < 0) begin
          second_done = e;
          start3 = 1'b0;
          n_checks++;
          if (diff3 !== 3'd6 || bout3 !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second: got diff=%0d bout=%b, want 6 1", diff3, bout3);
          end
        end
      end
    end
    start3 = 1'b0;
    n_checks++;
    if (first_done != 3 || second_done != 8) begin
      n_fail++;
      $display("FAIL b2b_spacing: got done at E%0d and E%0d, want E3 and E8",
               first_done, second_done);
    end
    $display("back_to_back: done at E%0d and E%0d", first_done, second_done);
    step();
    step();
  endtask

  task automatic test_wide();
    logic [7:0] od;
    logic       ob;
    int         nb;
    bit         tmo;
    logic [7:0] ra, rb;
    int         nbad = 0;
    run8(8'h00, 8'h01, od, ob, nb, tmo);
    n_checks++;
    if (tmo || od !== 8'hFF || ob !== 1'b1 || nb != 8) begin
      n_fail++;
      $display("FAIL wide_0_1: got diff=%0h bout=%b busy_cycles=%0d timeout=%b, want ff 1 8",
               od, ob, nb, tmo);
    end
    $display("wide: 00-01 -> diff=%0h bout=%b busy_cycles=%0d", od, ob, nb);
    step();
    for (int i = 0; i < 200; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      if (i == 0) begin ra = 8'hFF; rb = 8'h00; end
      if (i == 1) begin ra = 8'h80; rb = 8'h80; end
      run8(ra, rb, od, ob, nb, tmo);
      n_checks++;
      if (tmo || od !== 8'(ra - rb) || ob !== (ra < rb)) begin
        n_fail++;
        nbad++;
        $display("FAIL wide_rand %0h-%0h: got diff=%0h bout=%b timeout=%b, want diff=%0h bout=%b",
                 ra, rb, od, ob, tmo, 8'(ra - rb), (ra < rb));
      end
      step();
    end
    $display("wide_random: 200 ops, %0d wrong", nbad);
  endtask

  initial begin
    rst_n = 1'b0;
    start3 = 1'b0; a3 = '0; b3 = '0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    test_reset();
    test_basic();
    step();
    test_vectors();
    test_ignore_start();
    test_reset_midop();
    test_back_to_back();
    test_wide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
